demux_16bit_seq: RTL
====================

Name: demux_16bit_seq

Overview:
Registered 1-to-16 demultiplexer for 16-bit words. It is the write-side counterpart of multiplexer_16bit: it takes one word stream and distributes it into 16 holding registers, which can then feed the mux's I0..I15. Destination comes from an explicit 4-bit select or from an internal auto-increment pointer (frame mode). Per-channel valid and overrun flags plus a frame-complete pulse let a consumer drain channels with a clear handshake.

Parameters:
WIDTH, 16, data word width
CHANNELS, 16, number of output channels (power of two)
SEL_W, 4, select/pointer width, equal to log2(CHANNELS)

Ports:
clk  in  1  single clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data is written this cycle when high
in_data  in  WIDTH  input word
s  in  SEL_W  explicit destination select, used when auto_mode=0
auto_mode  in  1  1 = destination is the internal pointer; 0 = destination is s
valid_clr  in  CHANNELS  per-channel consumer acknowledge; clears out_valid[i]
out_bus  out  WIDTH*CHANNELS  channel i holding register is out_bus[i*WIDTH +: WIDTH]
out_valid  out  CHANNELS  channel i holds unconsumed data
overrun  out  CHANNELS  sticky: channel i was overwritten while still valid
ptr  out  SEL_W  current auto-mode pointer
frame_done  out  1  one-cycle pulse after channel CHANNELS-1 is written in auto mode

Behaviour:
- Reset (rst=1 at clk edge) has priority over all other inputs. out_bus, out_valid, overrun, ptr and frame_done all go to 0. A reset in the middle of a frame discards partial frame state; ptr restarts at 0.
- Destination: tgt = auto_mode ? ptr : s, sampled in the same cycle as in_valid.
- Write (in_valid=1):
  - Next edge: register[tgt] <= in_data and out_valid[tgt] <= 1.
  - Latency is 1 cycle from in_valid to visible out_bus/out_valid.
  - All other channel registers hold their values.
- Overrun:
  - Set overrun[tgt] if a write hits a channel with out_valid[tgt]=1 and valid_clr[tgt]=0.
  - Data is still overwritten.
  - overrun clears only on rst.
- Clear: valid_clr[i]=1 clears out_valid[i] at the next edge.
  - If a write to channel i occurs in the same cycle, the write wins: out_valid[i] stays 1 and no overrun is flagged.
  - valid_clr on a channel that is not valid has no effect.
  - Multiple clear bits may be set at once.
- Pointer (auto_mode=1 and in_valid=1):
  - ptr <= ptr+1 modulo CHANNELS.
  - From ptr=CHANNELS-1 it wraps to 0, and frame_done=1 for exactly the following cycle.
- Pointer when idle:
  - When auto_mode=0, ptr holds and frame_done stays 0.
  - Toggling auto_mode mid-frame resumes from the held ptr.
  - in_valid=0 leaves ptr unchanged in either mode.
- Select range: s is full range with no illegal values.
- Internal structure: no internal FSM beyond the pointer counter. All outputs are registered directly; there is no combinational path from inputs to outputs.

Decomposition:
- Package demux_pkg:
  - WIDTH and CHANNELS defaults, and SEL_W derived from them.
  - A word_t typedef.
  - The helper constant LAST_CH = CHANNELS-1.
- Sub-module demux_chan_reg, instantiated CHANNELS times via generate:
  - Holds one data register plus its valid and overrun bits.
  - Inputs: wr_en, clr, d.
- The top level holds:
  - the pointer counter;
  - the tgt decode to a one-hot wr_en vector;
  - frame_done generation.

Test Plan:
- Explicit-select sweep: rst, then auto_mode=0, in_valid=1 with s=0..15 and data AAAA, BBBB, CCCC, DDDD, EEEE, FFFF, 1234, 5678, 9ABC, DEF0, 1111..6666 -> one cycle later each channel i holds its word; out_valid goes 0x0001, 0x0003, ... up to 0xFFFF; overrun=0; ptr=0.
- Auto frame: auto_mode=1 with 16 consecutive writes of 0x0000..0x000F -> channel i = i; ptr wraps 15->0; frame_done high for exactly one cycle after the 16th write; a second frame pulses again.
- Overrun vs. clear: write 0x1234 to ch3, then write 0x5678 to ch3 -> ch3=5678 and overrun=0x0008. Separately, write to ch5 with valid_clr[5]=1 in the same cycle as the second write -> out_valid[5]=1, overrun[5]=0.
- Clear handshake: with all channels valid, pulse valid_clr=0xF0F0 -> out_valid=0x0F0F the next cycle; data unchanged.
- Reset mid-frame and idle hold:
  - In auto mode, write 5 words, assert rst for one cycle -> all outputs 0 and ptr=0.
  - Then auto_mode=0 with in_valid=0 for 10 cycles -> no state change.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-16 word demultiplexer.
// The top level and the channel registers take their parameter defaults from here.
package demux_pkg;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 16;
  localparam int SEL_W    = $clog2(CHANNELS);
  localparam int LAST_CH  = CHANNELS - 1;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/demux_chan_reg.sv
// One demux output channel: a holding register plus its valid and sticky overrun bits.
// A write in the same cycle as a consumer clear wins and does not count as an overrun.
module demux_chan_reg
  #(parameter int WIDTH = demux_pkg::WIDTH)
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overrun
  );

  import demux_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (wr_en) begin
      q     <= d;
      valid <= 1'b1;
      // Overrun only when the old word was still unconsumed and is not being acknowledged now.
      if (valid && !clr) begin
        overrun <= 1'b1;
      end
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_16bit_seq.sv
// Registered 1-to-CHANNELS demultiplexer with an explicit select or an auto-increment frame pointer.
// Every output comes straight from a flop, so there is no input-to-output combinational path.
module demux_16bit_seq
  #(
    parameter int WIDTH    = demux_pkg::WIDTH,
    parameter int CHANNELS = demux_pkg::CHANNELS,
    parameter int SEL_W    = demux_pkg::SEL_W
  )
  (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          s,
    input  logic                      auto_mode,
    input  logic [CHANNELS-1:0]       valid_clr,
    output logic [WIDTH*CHANNELS-1:0] out_bus,
    output logic [CHANNELS-1:0]       out_valid,
    output logic [CHANNELS-1:0]       overrun,
    output logic [SEL_W-1:0]          ptr,
    output logic                      frame_done
  );

  import demux_pkg::*;

  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    tgt;
  logic [CHANNELS-1:0] wr_en;
  logic                ptr_step;

  assign tgt      = auto_mode ? ptr : s;
  assign ptr_step = in_valid && auto_mode;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_en[i] = in_valid && (tgt == SEL_W'(i));
    end
  end

  // Pointer advances only on auto-mode writes; wrapping from the last channel marks a complete frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ptr_step && (ptr == PTR_LAST);
      if (ptr_step) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .clr     (valid_clr[g]),
      .d       (in_data),
      .q       (out_bus[g*WIDTH +: WIDTH]),
      .valid   (out_valid[g]),
      .overrun (overrun[g])
    );
  end

endmodule
